data_mem_arbiter: RTL and testbench

Controller that sits between the pipeline MEM stage and the byte-addressed 512-byte data memory. It shares the single memory port between the pipeline and a word-burst DMA channel, which is used for loading and dumping memory. The pipeline has priority, and a starvation counter guarantees the DMA forward progress. The block sequences DMA bursts with address generation and a valid/ready handshake, and stalls the pipeline when it steals a cycle.

---
 rtl/data_mem_arbiter_pkg.sv | 16 +
 rtl/mem_arb_starve_cnt.sv | 25 ++
 rtl/data_mem_arbiter.sv | 109 ++++++++++
 tb/tb_data_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared encodings for the data memory arbiter: access sizes, FSM states, memory size.
package data_mem_arbiter_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int MEM_BYTES = 512;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating count of cycles the DMA has waited; at_limit forces the next DMA grant.
module mem_arb_starve_cnt #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clr)
      cnt <= '0;
    else if (inc && !at_limit)
      cnt <= cnt + CW'(1);
  end

  assign at_limit = (cnt == CW'(LIMIT));

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one memory port between the pipeline MEM stage (priority, combinational)
// and a word-burst DMA channel that steals a cycle once it has starved long enough.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int LEN_W        = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [31:0]       p_wdata,
  input  logic [1:0]        p_size,
  input  logic              p_rw,
  output logic [31:0]       p_rdata,
  output logic              p_stall,
  input  logic              d_start,
  input  logic [ADDR_W-1:0] d_base,
  input  logic [LEN_W-1:0]  d_len,
  input  logic              d_dir,
  output logic              d_busy,
  output logic              d_done,
  input  logic [31:0]       d_wdata,
  input  logic              d_wvalid,
  output logic              d_wready,
  output logic [31:0]       d_rdata,
  output logic              d_rvalid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_di,
  output logic [1:0]        m_size,
  output logic              m_rw,
  output logic              m_e,
  input  logic [31:0]       m_do
);

  arb_state_e        state;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  remaining;
  logic              dir;
  logic              eligible, grant, at_limit;

  assign eligible = (state == RUN) && (!dir || d_wvalid);
  assign grant    = !reset && eligible && (!p_req || at_limit);

  mem_arb_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .reset    (reset),
    .inc      (eligible && !grant),
    .clr      (grant || (state == IDLE)),
    .at_limit (at_limit)
  );

  // DMA reads leave m_e low: the memory read path is combinational.
  always_comb begin
    m_addr   = p_addr;
    m_di     = p_wdata;
    m_size   = p_size;
    m_rw     = p_rw;
    m_e      = p_req && !reset;
    d_wready = 1'b0;
    if (grant) begin
      m_addr   = cur_addr;
      m_di     = d_wdata;
      m_size   = SZ_WORD;
      m_rw     = dir;
      m_e      = dir;
      d_wready = dir;
    end
  end

  assign p_stall = p_req && grant;
  assign p_rdata = m_do;
  assign d_busy  = (state == RUN);
  assign d_done  = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      d_rdata   <= '0;
      d_rvalid  <= 1'b0;
    end else begin
      d_rvalid <= grant && !dir;
      if (grant && !dir)
        d_rdata <= m_do;
      case (state)
        IDLE: if (d_start) begin
          cur_addr  <= d_base & ~ADDR_W'(3);
          remaining <= d_len;
          dir       <= d_dir;
          state     <= (d_len == '0) ? DONE : RUN;
        end
        RUN: if (grant) begin
          cur_addr  <= (cur_addr + ADDR_W'(4)) & ADDR_W'(MEM_BYTES - 1);
          remaining <= remaining - LEN_W'(1);
          if (remaining == LEN_W'(1))
            state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter: byte memory model plus write/read beat scoreboards.
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_req, p_rw;
  logic [8:0]  p_addr;
  logic [31:0] p_wdata, p_rdata;
  logic [1:0]  p_size;
  logic        p_stall;
  logic        d_start, d_dir, d_busy, d_done;
  logic [8:0]  d_base;
  logic [7:0]  d_len;
  logic [31:0] d_wdata, d_rdata;
  logic        d_wvalid, d_wready, d_rvalid;
  logic [8:0]  m_addr;
  logic [31:0] m_di, m_do;
  logic [1:0]  m_size;
  logic        m_rw, m_e;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  logic [40:0] exp_wr[$];   // {addr, data}
  logic [31:0] exp_rd[$];
  logic [7:0]  mem[512];

  data_mem_arbiter #(.ADDR_W(9), .LEN_W(8), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_addr(p_addr), .p_wdata(p_wdata), .p_size(p_size), .p_rw(p_rw),
    .p_rdata(p_rdata), .p_stall(p_stall),
    .d_start(d_start), .d_base(d_base), .d_len(d_len), .d_dir(d_dir),
    .d_busy(d_busy), .d_done(d_done),
    .d_wdata(d_wdata), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid),
    .m_addr(m_addr), .m_di(m_di), .m_size(m_size), .m_rw(m_rw), .m_e(m_e), .m_do(m_do)
  );

  always #5 clk = ~clk;

  always_comb m_do = {mem[{m_addr[8:2], 2'd3}], mem[{m_addr[8:2], 2'd2}],
                      mem[{m_addr[8:2], 2'd1}], mem[{m_addr[8:2], 2'd0}]};

  always @(posedge clk) begin
    if (m_e && m_rw) begin
      case (m_size)
        SZ_BYTE: mem[m_addr] <= m_di[7:0];
        SZ_HALF: begin
          mem[{m_addr[8:1], 1'b0}] <= m_di[7:0];
          mem[{m_addr[8:1], 1'b1}] <= m_di[15:8];
        end
        default: begin
          mem[{m_addr[8:2], 2'd0}] <= m_di[7:0];
          mem[{m_addr[8:2], 2'd1}] <= m_di[15:8];
          mem[{m_addr[8:2], 2'd2}] <= m_di[23:16];
          mem[{m_addr[8:2], 2'd3}] <= m_di[31:24];
        end
      endcase
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every consumed write beat and every read beat is matched against the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (d_wready) begin
        check("wr_beat_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          logic [40:0] e;
          e = exp_wr.pop_front();
          check("wr_beat_addr", 32'(m_addr), 32'(e[40:32]));
          check("wr_beat_data", m_di, e[31:0]);
          check("wr_beat_me", 32'(m_e), 32'd1);
        end
      end
      if (d_rvalid) begin
        check("rd_beat_expected", 32'(exp_rd.size() != 0), 32'd1);
        if (exp_rd.size() != 0) check("rd_beat_data", d_rdata, exp_rd.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic pwrite(input logic [8:0] a, input logic [31:0] d);
    p_req = 1'b1; p_rw = 1'b1; p_size = SZ_WORD; p_addr = a; p_wdata = d;
    tick;
    p_req = 1'b0; p_rw = 1'b0;
  endtask

  task automatic pread(input string name, input logic [8:0] a, input logic [31:0] exp);
    p_req = 1'b1; p_rw = 1'b0; p_size = SZ_WORD; p_addr = a;
    @(negedge clk);
    check(name, p_rdata, exp);
    check({name, "_stall"}, 32'(p_stall), 32'd0);
    tick;
    p_req = 1'b0;
  endtask

  task automatic dstart(input logic [8:0] base, input logic [7:0] len, input logic dir);
    d_base = base; d_len = len; d_dir = dir; d_start = 1'b1;
    tick;
    d_start = 1'b0;
  endtask

  initial begin
    int first_st, second_st, n_st;
    logic [31:0] wv_pat;
    logic [31:0] wd_pat[3];
    reset = 1'b1; p_req = 1'b1; p_rw = 1'b1; p_addr = 9'h0; p_wdata = '0; p_size = SZ_WORD;
    d_start = 1'b0; d_base = '0; d_len = '0; d_dir = 1'b0; d_wdata = '0; d_wvalid = 1'b0;
    tick;
    // Reset state, with a pipeline write pending that must not reach memory
    @(negedge clk);
    check("rst_m_e", 32'(m_e), 32'd0);
    check("rst_p_stall", 32'(p_stall), 32'd0);
    check("rst_busy_done", {30'd0, d_busy, d_done}, 32'd0);
    check("rst_wready_rvalid", {30'd0, d_wready, d_rvalid}, 32'd0);
    check("rst_rdata", d_rdata, 32'd0);
    tick;
    reset = 1'b0; p_req = 1'b0;
    tick;

    // Pipeline only
    p_req = 1'b1; p_rw = 1'b1; p_addr = 9'h010; p_wdata = 32'hDEADBEEF; p_size = SZ_WORD;
    @(negedge clk);
    check("pipe_wr_me", 32'(m_e), 32'd1);
    check("pipe_wr_stall", 32'(p_stall), 32'd0);
    tick;
    p_req = 1'b0;
    pread("pipe_rd", 9'h010, 32'hDEADBEEF);

    // DMA write, no contention
    for (int i = 0; i < 3; i++) exp_wr.push_back({9'h020 + 9'(4 * i), 32'hA000_0000 + 32'(i)});
    d_wvalid = 1'b1;
    dstart(9'h020, 8'd3, 1'b1);
    for (int i = 0; i < 3; i++) begin
      d_wdata = 32'hA000_0000 + 32'(i);
      @(negedge clk);
      check("dwr_wready", 32'(d_wready), 32'd1);
      check("dwr_done_early", 32'(d_done), 32'd0);
      tick;
    end
    @(negedge clk);
    check("dwr_done", 32'(d_done), 32'd1);
    check("dwr_wready_after", 32'(d_wready), 32'd0);
    tick;
    d_wvalid = 1'b0;
    pread("dwr_mem_024", 9'h024, 32'hA000_0001);

    // Starvation: continuous pipeline reads, DMA read of 2 words
    exp_rd.push_back(32'hA000_0000);
    exp_rd.push_back(32'hA000_0001);
    p_req = 1'b1; p_rw = 1'b0; p_addr = 9'h010;
    dstart(9'h020, 8'd2, 1'b0);
    first_st = -1; second_st = -1; n_st = 0;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      if (p_stall) begin
        n_st++;
        if (first_st < 0) first_st = c; else if (second_st < 0) second_st = c;
      end
      if (c == 11) check("starve_done", 32'(d_done), 32'd1);
      tick;
    end
    p_req = 1'b0;
    check("starve_first_grant", 32'(first_st), 32'd5);
    check("starve_second_grant", 32'(second_st), 32'd10);
    check("starve_stall_count", 32'(n_st), 32'd2);

    // Address wrap on a read burst; low base bits must be ignored
    pwrite(9'h1FC, 32'h1111_2222);
    pwrite(9'h000, 32'h3333_4444);
    exp_rd.push_back(32'h1111_2222);
    exp_rd.push_back(32'h3333_4444);
    dstart(9'h1FE, 8'd2, 1'b0);
    @(negedge clk);
    check("wrap_addr0", 32'(m_addr), 32'h1FC);
    check("wrap_busy", 32'(d_busy), 32'd1);
    tick;
    @(negedge clk);
    check("wrap_addr1", 32'(m_addr), 32'h000);
    tick;
    @(negedge clk);
    check("wrap_done", 32'(d_done), 32'd1);
    tick;

    // Zero-length burst
    d_base = 9'h100; d_len = 8'd0; d_dir = 1'b1; d_start = 1'b1; d_wvalid = 1'b1;
    @(negedge clk);
    check("noop_me_start", 32'(m_e), 32'd0);
    tick;
    d_start = 1'b0;
    @(negedge clk);
    check("noop_done", 32'(d_done), 32'd1);
    check("noop_me", 32'(m_e), 32'd0);
    check("noop_busy", 32'(d_busy), 32'd0);
    tick;
    @(negedge clk);
    check("noop_done_pulse", 32'(d_done), 32'd0);
    tick;
    d_wvalid = 1'b0;

    // Write throttling: d_wvalid 1,0,1
    exp_wr.push_back({9'h040, 32'hB000_0000});
    exp_wr.push_back({9'h044, 32'hB000_0001});
    wv_pat = 32'b101;
    wd_pat[0] = 32'hB000_0000; wd_pat[1] = 32'hDEAD_DEAD; wd_pat[2] = 32'hB000_0001;
    dstart(9'h040, 8'd2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      d_wvalid = wv_pat[i];
      d_wdata  = wd_pat[i];
      @(negedge clk);
      check("thr_wready", 32'(d_wready), 32'(wv_pat[i]));
      tick;
    end
    d_wvalid = 1'b0;
    @(negedge clk);
    check("thr_done", 32'(d_done), 32'd1);
    tick;
    pread("thr_mem_040", 9'h040, 32'hB000_0000);
    pread("thr_mem_044", 9'h044, 32'hB000_0001);

    // Reset during beat 2 of a 4-beat write
    pwrite(9'h084, 32'h55AA_55AA);
    exp_wr.push_back({9'h080, 32'hC000_0000});
    d_wvalid = 1'b1;
    dstart(9'h080, 8'd4, 1'b1);
    d_wdata = 32'hC000_0000;
    @(negedge clk);
    check("rst_burst_beat1", 32'(d_wready), 32'd1);
    tick;
    reset = 1'b1; d_wdata = 32'hC000_0001;
    @(negedge clk);
    check("rst_burst_me", 32'(m_e), 32'd0);
    tick;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_after_busy", 32'(d_busy), 32'd0);
      check("rst_after_done", 32'(d_done), 32'd0);
      check("rst_after_me", 32'(m_e), 32'd0);
      tick;
    end
    d_wvalid = 1'b0;
    pread("rst_mem_080", 9'h080, 32'hC000_0000);
    pread("rst_mem_084", 9'h084, 32'h55AA_55AA);

    tick;
    check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
